// File: rtl/tap_loader_mf_if.sv
// Bundles the ioctl download side, the RAM write port and the load-result status of tap_loader_mf.
// Handshakes: a byte enters the loader on every cycle with ioctl_download & ioctl_wr (the HPS stops
// while ioctl_wait=1). A RAM write is offered with mem_wr=1 and completes on the cycle mem_ready=1.
// mem_addr/mem_dout stay frozen while mem_wr=1 and mem_ready=0.
interface tap_loader_mf_if #(
    parameter int ADDR_W = 16
);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_dout;
    logic              mem_ready;
    logic              done;
    logic [15:0]       exec_addr;
    logic              exec_valid;
    logic [7:0]        file_type;
    logic [7:0]        file_count;
    logic [1:0]        error;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_dout, mem_ready,
        output ioctl_wait, mem_wr, mem_addr, mem_dout,
        output done, exec_addr, exec_valid, file_type, file_count, error
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_dout, mem_ready,
        input  ioctl_wait, mem_wr, mem_addr, mem_dout,
        input  done, exec_addr, exec_valid, file_type, file_count, error
    );
endinterface

// File: rtl/tap_loader_mf.sv
// Lynx .TAP image parser: buffers ioctl download bytes, writes file payloads into RAM through a
// stallable write port, verifies each checksum and reports type, exec address and load errors.
module tap_loader_mf #(
    parameter int          ADDR_W     = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] BASIC_LOAD = 16'h694D,
    parameter logic [15:0] DATA_LOAD  = 16'h694D,
    parameter bit          MULTI_FILE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    tap_loader_mf_if.slave bus,
    output logic [3:0]   dbg_state_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [7:0] T_A = 8'h41;
    localparam logic [7:0] T_B = 8'h42;
    localparam logic [7:0] T_D = 8'h44;
    localparam logic [7:0] T_M = 8'h4D;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_NAME    = 4'd1,
        S_TYPE    = 4'd2,
        S_LENLO   = 4'd3,
        S_LENHI   = 4'd4,
        S_LOADLO  = 4'd5,
        S_LOADHI  = 4'd6,
        S_PAYLOAD = 4'd7,
        S_CHECK   = 4'd8,
        S_EXECLO  = 4'd9,
        S_EXECHI  = 4'd10,
        S_FINISH  = 4'd11,
        S_SKIP    = 4'd12
    } state_t;

    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              empty, full, push, push_ok, pop;
    logic [7:0]        head;

    state_t            state_q;
    logic              dl_q;
    logic              dl_rise, trunc, accept, type_ok;
    logic [15:0]       len_q;
    logic [ADDR_W-1:0] load_q;
    logic [7:0]        lo_q;
    logic [7:0]        sum_q;
    logic              mem_wr_q;
    logic [7:0]        mem_dout_q;
    logic              done_q;
    logic [15:0]       exec_addr_q;
    logic              exec_valid_q;
    logic [7:0]        file_type_q;
    logic [7:0]        file_count_q;
    logic [1:0]        error_q;
    logic [1:0]        err_evt;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign push    = bus.ioctl_download & bus.ioctl_wr;
    assign push_ok = push & ~full;
    assign head    = fifo_q[rd_ptr_q];
    assign dl_rise = bus.ioctl_download & ~dl_q;
    assign accept  = mem_wr_q & bus.mem_ready;
    assign type_ok = (head == T_B) || (head == T_M) || (head == T_D) || (head == T_A);

    // Stream ended with the file still open and nothing left to parse.
    assign trunc = ~bus.ioctl_download & empty &
                   (state_q != S_IDLE) & (state_q != S_SKIP) & (state_q != S_FINISH);

    always_comb begin
        pop = 1'b0;
        if (!empty && !dl_rise) begin
            case (state_q)
                S_FINISH:  pop = 1'b0;
                // The last payload byte must retire before the checksum byte is consumed.
                S_PAYLOAD: pop = ~mem_wr_q | (bus.mem_ready & (len_q != 16'd1));
                default:   pop = 1'b1;
            endcase
        end
    end

    always_comb begin
        err_evt = 2'd0;
        if (push && full)                                   err_evt = 2'd3;
        else if (trunc)                                     err_evt = 2'd3;
        else if (state_q == S_TYPE && pop && head != 8'hA5 && !type_ok) err_evt = 2'd2;
        else if (state_q == S_CHECK && pop && head != sum_q) err_evt = 2'd1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q] <= bus.ioctl_dout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            dl_q         <= 1'b0;
            len_q        <= '0;
            load_q       <= '0;
            lo_q         <= '0;
            sum_q        <= '0;
            mem_wr_q     <= 1'b0;
            mem_dout_q   <= '0;
            done_q       <= 1'b0;
            exec_addr_q  <= '0;
            exec_valid_q <= 1'b0;
            file_type_q  <= '0;
            file_count_q <= '0;
            error_q      <= '0;
        end else begin
            dl_q   <= bus.ioctl_download;
            done_q <= 1'b0;

            if (dl_rise)                            error_q <= 2'd0;
            else if (error_q == 2'd0 && err_evt != 2'd0) error_q <= err_evt;

            if (dl_rise) begin
                state_q      <= S_IDLE;
                mem_wr_q     <= 1'b0;
                file_count_q <= '0;
                exec_valid_q <= 1'b0;
            end else if (trunc) begin
                state_q  <= S_IDLE;
                mem_wr_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (pop && head == 8'h22) state_q <= S_NAME;
                    S_NAME: if (pop && head == 8'h22) begin
                        state_q <= S_TYPE;
                        sum_q   <= '0;
                    end
                    S_TYPE: if (pop && head != 8'hA5) begin
                        if (type_ok) begin
                            file_type_q <= head;
                            state_q     <= S_LENLO;
                        end else begin
                            state_q <= S_SKIP;
                        end
                    end
                    S_LENLO: if (pop) begin
                        len_q[7:0] <= head;
                        state_q    <= S_LENHI;
                    end
                    S_LENHI: if (pop) begin
                        len_q[15:8] <= head;
                        if (file_type_q == T_M) begin
                            state_q <= S_LOADLO;
                        end else begin
                            load_q  <= (file_type_q == T_B) ? ADDR_W'(BASIC_LOAD) : ADDR_W'(DATA_LOAD);
                            state_q <= ({head, len_q[7:0]} == 16'd0) ? S_CHECK : S_PAYLOAD;
                        end
                    end
                    S_LOADLO: if (pop) begin
                        lo_q    <= head;
                        state_q <= S_LOADHI;
                    end
                    S_LOADHI: if (pop) begin
                        load_q  <= ADDR_W'({head, lo_q});
                        state_q <= (len_q == 16'd0) ? S_CHECK : S_PAYLOAD;
                    end
                    S_PAYLOAD: begin
                        if (accept) begin
                            mem_wr_q <= 1'b0;
                            load_q   <= load_q + 1'b1;
                            len_q    <= len_q - 16'd1;
                            if (len_q == 16'd1) state_q <= S_CHECK;
                        end
                        // A pop on the accept cycle chains straight into the next write.
                        if (pop) begin
                            mem_wr_q   <= 1'b1;
                            mem_dout_q <= head;
                            sum_q      <= sum_q + head;
                        end
                    end
                    S_CHECK: if (pop) begin
                        if (file_type_q == T_M) begin
                            state_q <= S_EXECLO;
                        end else begin
                            exec_valid_q <= 1'b0;
                            state_q      <= S_FINISH;
                        end
                    end
                    S_EXECLO: if (pop) begin
                        lo_q    <= head;
                        state_q <= S_EXECHI;
                    end
                    S_EXECHI: if (pop) begin
                        exec_addr_q  <= {head, lo_q};
                        exec_valid_q <= 1'b1;
                        state_q      <= S_FINISH;
                    end
                    S_FINISH: begin
                        done_q <= 1'b1;
                        if (file_count_q != 8'hFF) file_count_q <= file_count_q + 8'd1;
                        state_q <= MULTI_FILE ? S_IDLE : S_SKIP;
                    end
                    S_SKIP: if (!bus.ioctl_download && empty) state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.ioctl_wait = (count_q >= CW'(FIFO_DEPTH - 2));
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_addr   = load_q;
    assign bus.mem_dout   = mem_dout_q;
    assign bus.done       = done_q;
    assign bus.exec_addr  = exec_addr_q;
    assign bus.exec_valid = exec_valid_q;
    assign bus.file_type  = file_type_q;
    assign bus.file_count = file_count_q;
    assign bus.error      = error_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_tap_loader_mf.sv
// Bench for tap_loader_mf: builds TAP images, streams them over ioctl, scoreboards RAM writes.
module tb_tap_loader_mf;
    localparam logic [7:0] T_A = 8'h41;
    localparam logic [7:0] T_B = 8'h42;
    localparam logic [7:0] T_D = 8'h44;
    localparam logic [7:0] T_M = 8'h4D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tap_loader_mf_if #(.ADDR_W(16)) bus0 ();
    tap_loader_mf_if #(.ADDR_W(16)) bus1 ();
    logic [3:0] dbg0, dbg1;

    tap_loader_mf #(.MULTI_FILE(1'b1)) dut0 (.clk(clk), .reset(rst_n), .bus(bus0), .dbg_state_o(dbg0));
    tap_loader_mf #(.MULTI_FILE(1'b0)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1), .dbg_state_o(dbg1));

    assign bus1.ioctl_download = bus0.ioctl_download;
    assign bus1.ioctl_wr       = bus0.ioctl_wr;
    assign bus1.ioctl_dout     = bus0.ioctl_dout;
    assign bus1.mem_ready      = 1'b1;

    int total = 0;
    int bad = 0;
    logic [23:0] exp_q[$];
    logic [7:0]  img_q[$];
    logic [7:0]  pay_q[$];

    int ready_mode = 0;
    int stall_left = 0;
    bit stall_started = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int done1_cnt = 0;
    bit wait_seen = 0;
    bit stalled = 0;
    logic rdy;
    logic [15:0] hold_addr;
    logic [7:0]  hold_data;
    logic [23:0] exp_w;

    // RAM-side responder and scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus0.mem_ready = 1'b0;
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                total++;
                if (bus0.mem_wr !== 1'b1 || bus0.mem_addr !== hold_addr || bus0.mem_dout !== hold_data) begin
                    bad++;
                    $display("FAIL stall_hold got wr=%b addr=%h data=%h exp wr=1 addr=%h data=%h",
                             bus0.mem_wr, bus0.mem_addr, bus0.mem_dout, hold_addr, hold_data);
                end
            end
            if (ready_mode == 2 && !stall_started && bus0.mem_wr && acc_cnt == 2) begin
                stall_left = 10;
                stall_started = 1;
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                2:       rdy = (stall_left == 0);
                default: rdy = 1'b0;
            endcase
            if (stall_left > 0) stall_left--;
            bus0.mem_ready = rdy;
            if (bus0.mem_wr && rdy) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL write_unexpected got addr=%h data=%h exp none", bus0.mem_addr, bus0.mem_dout);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({bus0.mem_addr, bus0.mem_dout} !== exp_w) begin
                        bad++;
                        $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                                 bus0.mem_addr, bus0.mem_dout, exp_w[23:8], exp_w[7:0]);
                    end
                end
                acc_cnt++;
            end
            stalled   = bus0.mem_wr && !rdy;
            hold_addr = bus0.mem_addr;
            hold_data = bus0.mem_dout;
            if (bus0.ioctl_wait) wait_seen = 1;
            if (bus0.done) done_cnt++;
            if (bus1.done) done1_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        done_cnt = 0;
        done1_cnt = 0;
        wait_seen = 0;
        acc_cnt = 0;
        stall_started = 0;
        stall_left = 0;
        img_q.delete();
        exp_q.delete();
        pay_q.delete();
    endtask

    // Appends one file built from pay_q to the image and queues its expected RAM writes.
    task automatic add_file(input logic [7:0] typ, input logic [15:0] load, input logic [15:0] exec,
                            input bit bad_ck, input bit preamble);
        logic [7:0]  sum;
        logic [15:0] addr;
        logic [15:0] len;
        len = 16'(pay_q.size());
        img_q.push_back(8'h22);
        img_q.push_back(8'h54);
        img_q.push_back(8'h22);
        if (preamble) img_q.push_back(8'hA5);
        img_q.push_back(typ);
        img_q.push_back(len[7:0]);
        img_q.push_back(len[15:8]);
        if (typ == T_M) begin
            img_q.push_back(load[7:0]);
            img_q.push_back(load[15:8]);
            addr = load;
        end else begin
            addr = 16'h694D;
        end
        sum = 8'h00;
        foreach (pay_q[i]) begin
            img_q.push_back(pay_q[i]);
            exp_q.push_back({addr, pay_q[i]});
            addr = addr + 16'd1;
            sum = sum + pay_q[i];
        end
        img_q.push_back(bad_ck ? sum + 8'd1 : sum);
        if (typ == T_M) begin
            img_q.push_back(exec[7:0]);
            img_q.push_back(exec[15:8]);
        end
    endtask

    // Streams the first n image bytes honouring ioctl_wait, then ends the download and lets it drain.
    task automatic send_image(input int n);
        int i;
        int guard;
        @(negedge clk);
        bus0.ioctl_download = 1'b1;
        @(negedge clk);
        i = 0;
        guard = 0;
        while (i < n) begin
            if (!bus0.ioctl_wait) begin
                bus0.ioctl_wr = 1'b1;
                bus0.ioctl_dout = img_q[i];
                i++;
            end else begin
                bus0.ioctl_wr = 1'b0;
            end
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                total++;
                bad++;
                $display("FAIL send_timeout got sent=%0d exp sent=%0d", i, n);
                break;
            end
        end
        bus0.ioctl_wr = 1'b0;
        bus0.ioctl_download = 1'b0;
        repeat (80) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus0.mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr got=%b exp=0", bus0.mem_wr); end
        total++; if (bus0.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus0.done); end
        total++; if (bus0.error !== 2'd0) begin bad++; $display("FAIL reset_error got=%0d exp=0", bus0.error); end
        total++; if (bus0.file_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus0.file_count); end
        total++; if (bus0.exec_valid !== 1'b0) begin bad++; $display("FAIL reset_exec_valid got=%b exp=0", bus0.exec_valid); end
        total++; if (bus0.ioctl_wait !== 1'b0) begin bad++; $display("FAIL reset_wait got=%b exp=0", bus0.ioctl_wait); end
        total++; if (dbg0 !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg0); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_type_b();
        clear_stats();
        pay_q = '{8'h01, 8'h02, 8'h03};
        add_file(T_B, 16'h0000, 16'h0000, 1'b0, 1'b0);
        ready_mode = 1;
        send_image(img_q.size());
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b_writes got left=%0d exp=0", exp_q.size()); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL b_done got=%0d exp=1", done_cnt); end
        total++; if (bus0.error !== 2'd0) begin bad++; $display("FAIL b_error got=%0d exp=0", bus0.error); end
        total++; if (bus0.exec_valid !== 1'b0) begin bad++; $display("FAIL b_exec_valid got=%b exp=0", bus0.exec_valid); end
        total++; if (bus0.file_count !== 8'd1) begin bad++; $display("FAIL b_count got=%0d exp=1", bus0.file_count); end
        total++; if (bus0.file_type !== T_B) begin bad++; $display("FAIL b_type got=%h exp=%h", bus0.file_type, T_B); end
    endtask

    task automatic test_type_m();
        clear_stats();
        pay_q = '{8'hAA, 8'h55};
        add_file(T_M, 16'h8000, 16'h8001, 1'b0, 1'b0);
        ready_mode = 1;
        send_image(img_q.size());
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL m_writes got left=%0d exp=0", exp_q.size()); end
        total++; if (bus0.exec_addr !== 16'h8001) begin bad++; $display("FAIL m_exec_addr got=%h exp=8001", bus0.exec_addr); end
        total++; if (bus0.exec_valid !== 1'b1) begin bad++; $display("FAIL m_exec_valid got=%b exp=1", bus0.exec_valid); end
        total++; if (bus0.file_type !== T_M) begin bad++; $display("FAIL m_type got=%h exp=%h", bus0.file_type, T_M); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL m_done got=%0d exp=1", done_cnt); end
        total++; if (bus0.error !== 2'd0) begin bad++; $display("FAIL m_error got=%0d exp=0", bus0.error); end
    endtask

    task automatic test_backpressure();
        clear_stats();
        for (int i = 0; i < 14; i++) pay_q.push_back(8'($urandom_range(0, 255)));
        add_file(T_B, 16'h0000, 16'h0000, 1'b0, 1'b0);
        ready_mode = 2;
        send_image(img_q.size());
        total++; if (!stall_started) begin bad++; $display("FAIL bp_stall got=0 exp=1"); end
        total++; if (wait_seen !== 1'b1) begin bad++; $display("FAIL bp_wait got=%b exp=1", wait_seen); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_writes got left=%0d exp=0", exp_q.size()); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done got=%0d exp=1", done_cnt); end
        total++; if (bus0.error !== 2'd0) begin bad++; $display("FAIL bp_error got=%0d exp=0", bus0.error); end
    endtask

    task automatic test_bad_checksum();
        clear_stats();
        pay_q = '{8'h01, 8'h02, 8'h03};
        add_file(T_B, 16'h0000, 16'h0000, 1'b1, 1'b0);
        ready_mode = 1;
        send_image(img_q.size());
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ck_writes got left=%0d exp=0", exp_q.size()); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL ck_done got=%0d exp=1", done_cnt); end
        total++; if (bus0.error !== 2'd1) begin bad++; $display("FAIL ck_error got=%0d exp=1", bus0.error); end
    endtask

    task automatic test_multi_file();
        clear_stats();
        pay_q = '{8'h10, 8'h20};
        add_file(T_B, 16'h0000, 16'h0000, 1'b0, 1'b0);
        pay_q = '{8'h07, 8'h08, 8'h09};
        add_file(T_D, 16'h0000, 16'h0000, 1'b0, 1'b1);
        ready_mode = 1;
        send_image(img_q.size());
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL multi_writes got left=%0d exp=0", exp_q.size()); end
        total++; if (done_cnt != 2) begin bad++; $display("FAIL multi_done got=%0d exp=2", done_cnt); end
        total++; if (bus0.file_count !== 8'd2) begin bad++; $display("FAIL multi_count got=%0d exp=2", bus0.file_count); end
        total++; if (bus0.file_type !== T_D) begin bad++; $display("FAIL multi_type got=%h exp=%h", bus0.file_type, T_D); end
        total++; if (done1_cnt != 1) begin bad++; $display("FAIL single_done got=%0d exp=1", done1_cnt); end
        total++; if (bus1.file_count !== 8'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", bus1.file_count); end
        total++; if (bus1.file_type !== T_B) begin bad++; $display("FAIL single_type got=%h exp=%h", bus1.file_type, T_B); end
    endtask

    task automatic test_zero_len();
        clear_stats();
        add_file(T_A, 16'h0000, 16'h0000, 1'b0, 1'b0);
        ready_mode = 1;
        send_image(img_q.size());
        total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done got=%0d exp=1", done_cnt); end
        total++; if (bus0.error !== 2'd0) begin bad++; $display("FAIL zero_error got=%0d exp=0", bus0.error); end
        total++; if (acc_cnt != 0) begin bad++; $display("FAIL zero_writes got=%0d exp=0", acc_cnt); end
    endtask

    task automatic test_bad_type();
        clear_stats();
        img_q = '{8'h22, 8'h54, 8'h22, 8'h58, 8'h02, 8'h00, 8'h05, 8'h06, 8'h0B};
        ready_mode = 1;
        send_image(img_q.size());
        total++; if (bus0.error !== 2'd2) begin bad++; $display("FAIL type_error got=%0d exp=2", bus0.error); end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL type_done got=%0d exp=0", done_cnt); end
        total++; if (acc_cnt != 0) begin bad++; $display("FAIL type_writes got=%0d exp=0", acc_cnt); end
    endtask

    task automatic test_truncate();
        clear_stats();
        pay_q = '{8'h01, 8'h02, 8'h03};
        add_file(T_B, 16'h0000, 16'h0000, 1'b0, 1'b0);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        ready_mode = 0;
        send_image(7);
        total++; if (bus0.error !== 2'd3) begin bad++; $display("FAIL trunc_error got=%0d exp=3", bus0.error); end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL trunc_done got=%0d exp=0", done_cnt); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL trunc_writes got left=%0d exp=0", exp_q.size()); end
        total++; if (dbg0 !== 4'd0) begin bad++; $display("FAIL trunc_state got=%0d exp=0", dbg0); end
        total++; if (bus0.file_count !== 8'd0) begin bad++; $display("FAIL trunc_count got=%0d exp=0", bus0.file_count); end
    endtask

    task automatic test_reset_mid_payload();
        int i;
        int guard;
        clear_stats();
        for (int k = 0; k < 8; k++) pay_q.push_back(8'($urandom_range(0, 255)));
        add_file(T_B, 16'h0000, 16'h0000, 1'b0, 1'b0);
        ready_mode = 3;
        @(negedge clk);
        bus0.ioctl_download = 1'b1;
        @(negedge clk);
        i = 0;
        guard = 0;
        while (bus0.mem_wr !== 1'b1 && guard < 200) begin
            if (!bus0.ioctl_wait && i < img_q.size()) begin
                bus0.ioctl_wr = 1'b1;
                bus0.ioctl_dout = img_q[i];
                i++;
            end else begin
                bus0.ioctl_wr = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        bus0.ioctl_wr = 1'b0;
        total++; if (bus0.mem_wr !== 1'b1) begin bad++; $display("FAIL rst_mid_wr_start got=%b exp=1", bus0.mem_wr); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus0.mem_wr !== 1'b0) begin bad++; $display("FAIL rst_mid_mem_wr got=%b exp=0", bus0.mem_wr); end
        total++; if (dbg0 !== 4'd0) begin bad++; $display("FAIL rst_mid_state got=%0d exp=0", dbg0); end
        total++; if (bus0.ioctl_wait !== 1'b0) begin bad++; $display("FAIL rst_mid_wait got=%b exp=0", bus0.ioctl_wait); end
        exp_q.delete();
        bus0.ioctl_download = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus0.ioctl_download = 1'b0;
        bus0.ioctl_wr = 1'b0;
        bus0.ioctl_dout = 8'h00;
        bus0.mem_ready = 1'b0;
        test_reset();
        test_type_b();
        test_type_m();
        test_backpressure();
        test_bad_checksum();
        test_multi_file();
        test_zero_len();
        test_bad_type();
        test_truncate();
        test_reset_mid_payload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
